// File: rtl/alu_op_issuer.sv
// Issues one decoded operation to a combinational ALU.
// Operands and control are held for a settle window, then the result, zero flag and branch decision are returned on a valid/ready port.
module alu_op_issuer #(
  parameter int WIDTH         = 32,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [2:0]       funct3,
  input  logic             funct7_5,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  input  logic [WIDTH-1:0] imm,
  input  logic             alu_src,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_taken,
  output logic             out_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             is_branch_q, is_branch_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic             out_taken_q, out_taken_d;
  logic             out_err_q, out_err_d;

  logic [3:0]       dec_ctrl;
  logic             dec_legal;

  always_comb begin
    dec_ctrl  = 4'b0010;
    dec_legal = 1'b1;
    case (alu_op)
      2'b00: dec_ctrl = 4'b0010;
      2'b01: dec_ctrl = 4'b0110;
      2'b10: begin
        case (funct3)
          3'b000:  dec_ctrl = funct7_5 ? 4'b0110 : 4'b0010;
          3'b111:  dec_ctrl = 4'b0000;
          3'b110:  dec_ctrl = 4'b0001;
          default: dec_legal = 1'b0;
        endcase
      end
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    is_branch_d  = is_branch_q;
    funct3_d     = funct3_q;
    out_result_d = out_result_q;
    out_taken_d  = out_taken_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          alu_a_d     = rs1_val;
          alu_b_d     = alu_src ? imm : rs2_val;
          is_branch_d = (alu_op == 2'b01);
          funct3_d    = funct3;
          if (dec_legal) begin
            alu_ctrl_d = dec_ctrl;
            cnt_d      = CNT_INIT;
            state_d    = EXEC;
          end else begin
            // Illegal ops bypass the ALU entirely; alu_ctrl keeps its old code.
            out_err_d    = 1'b1;
            out_result_d = '0;
            out_taken_d  = 1'b0;
            state_d      = RESP;
          end
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          out_result_d = alu_result;
          out_err_d    = 1'b0;
          out_taken_d  = is_branch_q &&
                         (((funct3_q == 3'b000) &&  alu_zero) ||
                          ((funct3_q == 3'b001) && !alu_zero));
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= '0;
      is_branch_q  <= 1'b0;
      funct3_q     <= '0;
      out_result_q <= '0;
      out_taken_q  <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      is_branch_q  <= is_branch_d;
      funct3_q     <= funct3_d;
      out_result_q <= out_result_d;
      out_taken_q  <= out_taken_d;
      out_err_q    <= out_err_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == RESP);
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign out_result = out_result_q;
  assign out_taken  = out_taken_q;
  assign out_err    = out_err_q;

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: two instances (settle 1 and settle 3) each driving a behavioural ALU.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic [31:0] rs1_val = '0, rs2_val = '0, imm = '0;
  logic        alu_src = 1'b0;

  logic        in_valid1, in_valid3, out_ready1, out_ready3;
  logic        in_ready1, in_ready3, out_valid1, out_valid3;
  logic [31:0] alu_a1, alu_b1, alu_a3, alu_b3;
  logic [3:0]  alu_ctrl1, alu_ctrl3;
  logic [31:0] alu_res1, alu_res3, out_result1, out_result3;
  logic        out_taken1, out_taken3, out_err1, out_err3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign in_valid1  = req_valid && !sel;
  assign in_valid3  = req_valid &&  sel;
  assign out_ready1 = rsp_ready && !sel;
  assign out_ready3 = rsp_ready &&  sel;

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_res1 = alu_f(alu_ctrl1, alu_a1, alu_b1);
  assign alu_res3 = alu_f(alu_ctrl3, alu_a3, alu_b3);

  alu_op_issuer #(.WIDTH(32), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .alu_src(alu_src),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_ctrl(alu_ctrl1),
    .alu_result(alu_res1), .alu_zero(alu_res1 == 32'd0),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_result(out_result1), .out_taken(out_taken1), .out_err(out_err1)
  );

  alu_op_issuer #(.WIDTH(32), .SETTLE_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .alu_src(alu_src),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_ctrl(alu_ctrl3),
    .alu_result(alu_res3), .alu_zero(alu_res3 == 32'd0),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_result(out_result3), .out_taken(out_taken3), .out_err(out_err3)
  );

  // Views of whichever instance is currently selected.
  logic        o_ready, o_valid, o_taken, o_err;
  logic [31:0] o_a, o_b, o_res;
  logic [3:0]  o_ctrl;
  assign o_ready = sel ? in_ready3   : in_ready1;
  assign o_valid = sel ? out_valid3  : out_valid1;
  assign o_taken = sel ? out_taken3  : out_taken1;
  assign o_err   = sel ? out_err3    : out_err1;
  assign o_a     = sel ? alu_a3      : alu_a1;
  assign o_b     = sel ? alu_b3      : alu_b1;
  assign o_res   = sel ? out_result3 : out_result1;
  assign o_ctrl  = sel ? alu_ctrl3   : alu_ctrl1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string tag, input logic s,
                     input logic [1:0] op, input logic [2:0] f3, input logic f75,
                     input logic [31:0] a, input logic [31:0] b, input logic [31:0] im, input logic src,
                     input logic [3:0] e_ctrl, input logic [31:0] e_a, input logic [31:0] e_b,
                     input logic [31:0] e_res, input logic e_taken, input logic e_err,
                     input int e_lat, input int hold);
    int lat;
    sel = s; alu_op = op; funct3 = f3; funct7_5 = f75;
    rs1_val = a; rs2_val = b; imm = im; alu_src = src;
    req_valid = 1'b1;
    #1;
    chk({tag, ".in_ready_idle"}, 32'(o_ready), 32'd1);
    step();
    req_valid = 1'b0;
    rs1_val = 32'h1234_5678; rs2_val = 32'h8765_4321; imm = 32'h0BAD_F00D;
    lat = 1;
    while (!o_valid && lat < 20) begin
      chk({tag, ".in_ready_exec"}, 32'(o_ready), 32'd0);
      chk({tag, ".alu_a"},    o_a, e_a);
      chk({tag, ".alu_b"},    o_b, e_b);
      chk({tag, ".alu_ctrl"}, 32'(o_ctrl), 32'(e_ctrl));
      step();
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    for (int h = 0; h <= hold; h++) begin
      chk({tag, ".out_valid"},  32'(o_valid), 32'd1);
      chk({tag, ".in_ready_resp"}, 32'(o_ready), 32'd0);
      chk({tag, ".out_result"}, o_res, e_res);
      chk({tag, ".out_taken"},  32'(o_taken), 32'(e_taken));
      chk({tag, ".out_err"},    32'(o_err), 32'(e_err));
      chk({tag, ".alu_ctrl_resp"}, 32'(o_ctrl), 32'(e_ctrl));
      if (h < hold) step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({tag, ".out_valid_drop"}, 32'(o_valid), 32'd0);
    chk({tag, ".in_ready_back"},  32'(o_ready), 32'd1);
    $display("txn %s: ctrl=%0h a=%0h b=%0h result=%0h taken=%0d err=%0d lat=%0d",
             tag, o_ctrl, o_a, o_b, o_res, o_taken, o_err, lat);
  endtask

  initial begin
    #12;
    chk("rst.in_ready1",   32'(in_ready1), 32'd1);
    chk("rst.out_valid1",  32'(out_valid1), 32'd0);
    chk("rst.alu_ctrl1",   32'(alu_ctrl1), 32'd0);
    chk("rst.alu_a1",      alu_a1, 32'd0);
    chk("rst.alu_b1",      alu_b1, 32'd0);
    chk("rst.out_result1", out_result1, 32'd0);
    chk("rst.out_taken1",  32'(out_taken1), 32'd0);
    chk("rst.out_err1",    32'(out_err1), 32'd0);
    chk("rst.in_ready3",   32'(in_ready3), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    //  tag        sel op     f3     f75   rs1           rs2           imm           src   ctrl     a             b             result        tk    err  lat hold
    txn("rsub",   0, 2'b10, 3'b000, 1'b1, 32'd7,        32'd9,        32'd0,        1'b0, 4'b0110, 32'd7,        32'd9,        32'hFFFF_FFFE, 1'b0, 1'b0, 2, 0);
    txn("ldadd",  0, 2'b00, 3'b010, 1'b0, 32'h100,      32'h55,       32'hFFFF_FFFC, 1'b1, 4'b0010, 32'h100,      32'hFFFF_FFFC, 32'hFC,       1'b0, 1'b0, 2, 0);
    txn("beq_eq", 0, 2'b01, 3'b000, 1'b0, 32'd5,        32'd5,        32'd0,        1'b0, 4'b0110, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0, 2, 0);
    txn("bne_eq", 0, 2'b01, 3'b001, 1'b0, 32'd5,        32'd5,        32'd0,        1'b0, 4'b0110, 32'd5,        32'd5,        32'd0,        1'b0, 1'b0, 2, 0);
    txn("bne_ne", 0, 2'b01, 3'b001, 1'b0, 32'd5,        32'd6,        32'd0,        1'b0, 4'b0110, 32'd5,        32'd6,        32'hFFFF_FFFF, 1'b1, 1'b0, 2, 0);
    txn("br_f4",  0, 2'b01, 3'b100, 1'b0, 32'd3,        32'd3,        32'd0,        1'b0, 4'b0110, 32'd3,        32'd3,        32'd0,        1'b0, 1'b0, 2, 0);
    txn("and",    0, 2'b10, 3'b111, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 4'b0000, 32'hF0F0,     32'hFF00,     32'hF000,     1'b0, 1'b0, 2, 0);
    txn("or",     0, 2'b10, 3'b110, 1'b1, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 4'b0001, 32'hF0F0,     32'hFF00,     32'hFFF0,     1'b0, 1'b0, 2, 0);
    txn("ill_rt", 0, 2'b10, 3'b100, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 4'b0001, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 1'b1, 1, 0);
    txn("ill_11", 0, 2'b11, 3'b000, 1'b0, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 4'b0001, 32'hF0F0,     32'hFF00,     32'd0,        1'b0, 1'b1, 1, 2);
    txn("radd_bp",0, 2'b10, 3'b000, 1'b0, 32'd3,        32'd4,        32'd0,        1'b0, 4'b0010, 32'd3,        32'd4,        32'd7,        1'b0, 1'b0, 2, 5);
    txn("s3_sub", 1, 2'b10, 3'b000, 1'b1, 32'd20,       32'd10,       32'd0,        1'b0, 4'b0110, 32'd20,       32'd10,       32'd10,       1'b0, 1'b0, 4, 5);
    txn("s3_beq", 1, 2'b01, 3'b000, 1'b0, 32'h77,       32'h77,       32'd0,        1'b0, 4'b0110, 32'h77,       32'h77,       32'd0,        1'b1, 1'b0, 4, 0);

    // Reset in the middle of the settle window on the slow instance.
    sel = 1'b1; alu_op = 2'b00; alu_src = 1'b0; rs1_val = 32'd1; rs2_val = 32'd2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    chk("mid.in_ready_exec", 32'(in_ready3), 32'd0);
    chk("mid.alu_ctrl_exec", 32'(alu_ctrl3), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 32'(out_valid3), 32'd0);
    chk("mid.in_ready",  32'(in_ready3), 32'd1);
    chk("mid.alu_ctrl",  32'(alu_ctrl3), 32'd0);
    chk("mid.alu_a",     alu_a3, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid.no_stale_valid", 32'(out_valid3), 32'd0);
      chk("mid.idle_ready",     32'(in_ready3), 32'd1);
    end
    $display("txn mid_reset: out_valid=%0d in_ready=%0d alu_ctrl=%0h", out_valid3, in_ready3, alu_ctrl3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_op_issuer.md
Name: alu_op_issuer

Overview:
Initiator side of the datapath ALU interface. It accepts one decoded operation per handshake and derives the 4-bit ALU control code from ALUOp/funct fields. It then drives registered operands and control onto the combinational ALU, samples the result and zero flag after a settle window, and returns the result plus a branch-taken decision through a valid/ready response port. It sits between instruction decode and the ALU in the processor core.

Parameters:
WIDTH, 32, operand/result width in bits
SETTLE_CYCLES, 1, cycles the ALU inputs are held before result/zero are sampled; legal range 1..15

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  issuer can accept a request
alu_op  input  2  00 load/store add, 01 branch compare, 10 R-type, 11 reserved
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
rs1_val  input  WIDTH  first source operand
rs2_val  input  WIDTH  second source operand
imm  input  WIDTH  sign-extended immediate
alu_src  input  1  1: B operand = imm, 0: B operand = rs2_val
alu_a  output  WIDTH  registered A operand to ALU
alu_b  output  WIDTH  registered B operand to ALU
alu_ctrl  output  4  registered ALU control code
alu_result  input  WIDTH  ALU result
alu_zero  input  1  ALU zero flag
out_valid  output  1  response valid
out_ready  input  1  consumer accepts response
out_result  output  WIDTH  captured ALU result
out_taken  output  1  branch taken
out_err  output  1  illegal operation

Behaviour:
- Reset (async assert, sync release): state IDLE. All outputs 0 except in_ready=1; the settle counter is 0. Asserting reset mid-transaction drops the transaction; no response is produced.
- Control decode:
  - alu_op=00 -> 0010 (add).
  - alu_op=01 -> 0110 (sub).
  - alu_op=10:
    - funct3=000 with funct7_5=0 -> 0010; with funct7_5=1 -> 0110.
    - funct3=111 -> 0000 (and).
    - funct3=110 -> 0001 (or).
    - any other funct3 -> illegal.
  - alu_op=11 -> illegal.
- FSM states IDLE, EXEC, RESP.
  - IDLE: in_ready=1. On in_valid, capture alu_a=rs1_val, alu_b=(alu_src?imm:rs2_val), and alu_ctrl=decoded code. Also capture the branch info (alu_op==01, funct3).
    - Legal op -> EXEC, counter loaded with SETTLE_CYCLES-1.
    - Illegal op -> RESP directly. alu_ctrl is not updated. out_err=1, out_result=0, out_taken=0.
  - EXEC: in_ready=0. alu_a/alu_b/alu_ctrl are held stable. The counter decrements each cycle. When the counter is 0, sample alu_result into out_result and compute out_taken, with out_err=0, then go to RESP.
    - out_taken = 1 only for branch ops: funct3=000 (beq) taken when alu_zero=1; funct3=001 (bne) taken when alu_zero=0.
    - Branch ops with any other funct3 give out_taken=0.
  - RESP: out_valid=1. out_result/out_taken/out_err are held stable while out_ready=0. On out_ready=1 -> IDLE and out_valid falls next cycle.
- Latency and throughput:
  - Legal op: out_valid rises SETTLE_CYCLES+1 cycles after the accept edge.
  - Illegal op: out_valid rises 1 cycle after the accept edge.
  - in_ready is 0 from the accept edge until the cycle after the response handshake. There is no same-cycle accept on response completion.
- alu_a/alu_b/alu_ctrl keep their last values in IDLE and RESP; they change only on accept.
- Result width is WIDTH; no arithmetic is performed internally, the value is passed through from the ALU.
- in_valid while in_ready=0 is ignored. Requesters must hold the request until it is accepted.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 in EXEC -> out_valid=0, in_ready=1, alu_ctrl=0 immediately (async); no stale response after release.
- R-type sub: alu_op=10, funct3=000, funct7_5=1, rs1=7, rs2=9, SETTLE_CYCLES=1 -> alu_ctrl=0110, alu_a=7, alu_b=9. out_valid 2 cycles after accept with out_result=0xFFFFFFFE, out_err=0.
- Load add with immediate: alu_op=00, alu_src=1, rs1=0x100, imm=0xFFFFFFFC -> alu_ctrl=0010, out_result=0xFC.
- Branch beq and bne:
  - beq (alu_op=01, funct3=000), rs1=rs2=5 -> out_taken=1.
  - bne (funct3=001), same operands -> out_taken=0.
  - bne with rs1=5, rs2=6 -> out_taken=1.
- Illegal op: alu_op=10, funct3=100 -> out_valid 1 cycle after accept, out_err=1, out_result=0, alu_ctrl unchanged.
- Backpressure and settle: out_ready=0 for 5 cycles in RESP -> outputs held stable, in_ready=0. With SETTLE_CYCLES=3, out_valid rises 4 cycles after accept and alu_a/alu_b/alu_ctrl stay constant throughout.
